// File: rtl/regfile_sb.sv
// Register bank: two bypassed read ports, one raw debug read port, one write port, and a
// per-register pending scoreboard that issue sets and writeback clears.
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter bit ZERO_REG0 = 1'b1,
    parameter bit WR_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;

    logic wr_ok, iss_ok, set_new, clr_old;

    // Issue after clear: a same-cycle issue to the written register keeps it pending.
    always_comb begin
        wr_ok      = wr_en && !(ZERO_REG0 && (wr_addr == '0));
        iss_ok     = iss_en && !flush && !(ZERO_REG0 && (iss_addr == '0));
        set_new    = iss_ok && !pend_q[iss_addr];
        clr_old    = wr_ok && pend_q[wr_addr] && !(iss_ok && (iss_addr == wr_addr));
        pend_d     = pend_q;
        pend_cnt_d = pend_cnt_q;
        if (flush) begin
            pend_d     = '0;
            pend_cnt_d = '0;
        end else begin
            if (wr_ok)  pend_d[wr_addr]  = 1'b0;
            if (iss_ok) pend_d[iss_addr] = 1'b1;
            pend_cnt_d = pend_cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = pend_q[rd_addr[p]];
            if (WR_BYPASS && wr_ok && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
                rd_busy[p] = iss_ok && (iss_addr == rd_addr[p]);
            end
            if (ZERO_REG0 && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];
    assign dbg_data = (ZERO_REG0 && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];
    assign pend_cnt = pend_cnt_q;

endmodule
